// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel
// plus the instruction handshake toward decode.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   modport master (
      output imem_req, imem_addr,
      output instr_valid, instr, instr_pc,
      input  imem_ready, imem_rvalid, imem_rdata,
      input  instr_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      input  instr_valid, instr, instr_pc,
      output imem_ready, imem_rvalid, imem_rdata,
      output instr_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding request, 2-entry buffer, redirects.
// Define DELAY_SLOT_EN to keep the branch delay slot across a redirect.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   instr_fetch_if.master bus,
   input  logic          branch_taken,
   input  logic [31:0]   branch_target,
   input  logic          jump,
   input  logic [25:0]   jump_index
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

`ifdef DELAY_SLOT_EN
   localparam logic DSLOT = 1'b1;
`else
   localparam logic DSLOT = 1'b0;
`endif

   logic [1:0]  st, st_n;
   logic [31:0] pc, pc_n;
   logic [31:0] tgt, tgt_n;
   logic [31:0] opc, opc_n;
   logic [31:0] last_pc;
   logic        drop, drop_n;
   logic        pend, pend_n;
   logic        pdrop, pdrop_n;

   logic [1:0]  cnt, n_cnt;
   logic [31:0] ins0, ins1, pc0, pc1;
   logic [31:0] n_ins0, n_ins1, n_pc0, n_pc1;

   logic        push, pop, accept, redir;
   logic        has_post, flush_all, space;
   logic [31:0] bpc, target;
   logic [3:0]  jhi;
   logic        unused;

   assign push   = (st == WAIT) && bus.imem_rvalid && !drop;
   assign pop    = (cnt != 2'd0) && bus.instr_ready;
   assign accept = (st == REQ) && bus.imem_ready;
   assign redir  = branch_taken || jump;

   // Jump region comes from the pc after the redirecting instruction.
   assign bpc    = pop ? pc0 : last_pc;
   assign jhi    = bpc[31:28] + {3'b000, &bpc[27:2]};
   assign target = branch_taken ? {branch_target[31:2], 2'b00}
                                : {jhi, jump_index, 2'b00};
   assign unused = &{1'b0, branch_target[1:0], bpc[1:0]};

   assign bus.imem_req    = (st == REQ);
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = (cnt != 2'd0);
   assign bus.instr       = ins0;
   assign bus.instr_pc    = pc0;

   always_comb begin
      n_ins0 = ins0;
      n_ins1 = ins1;
      n_pc0  = pc0;
      n_pc1  = pc1;
      n_cnt  = cnt;
      if (pop) begin
         n_ins0 = ins1;
         n_pc0  = pc1;
         n_cnt  = cnt - 2'd1;
      end
      if (push) begin
         if (n_cnt == 2'd0) begin
            n_ins0 = bus.imem_rdata;
            n_pc0  = opc;
         end else begin
            n_ins1 = bus.imem_rdata;
            n_pc1  = opc;
         end
         n_cnt = n_cnt + 2'd1;
      end
      has_post  = (n_cnt != 2'd0);
      flush_all = !DSLOT || has_post;
      if (redir)
         n_cnt = (DSLOT && has_post) ? 2'd1 : 2'd0;
      space = !n_cnt[1];
   end

   always_comb begin
      st_n    = st;
      pc_n    = pc;
      tgt_n   = tgt;
      opc_n   = opc;
      drop_n  = drop;
      pend_n  = pend;
      pdrop_n = pdrop;
      unique case (st)
         IDLE: if (space) st_n = REQ;
         REQ: begin
            if (accept) begin
               st_n  = WAIT;
               opc_n = pc;
               if (pend) begin
                  pc_n   = tgt;
                  pend_n = 1'b0;
                  drop_n = pdrop;
               end else begin
                  pc_n   = pc + 32'd4;
                  drop_n = 1'b0;
               end
            end
         end
         WAIT: begin
            if (bus.imem_rvalid) begin
               drop_n = 1'b0;
               st_n   = space ? REQ : IDLE;
            end
         end
         default: st_n = IDLE;
      endcase
      // A redirect either replaces pc now or parks the target in tgt
      // until the in-flight handshake (or delay-slot fetch) is done.
      if (redir) begin
         tgt_n = target;
         unique case (st)
            IDLE: begin
               st_n = REQ;
               if (flush_all) begin
                  pc_n   = target;
                  pend_n = 1'b0;
               end else begin
                  pend_n  = 1'b1;
                  pdrop_n = 1'b0;
               end
            end
            REQ: begin
               if (accept) begin
                  pc_n   = target;
                  pend_n = 1'b0;
                  drop_n = flush_all;
               end else begin
                  pend_n  = 1'b1;
                  pdrop_n = flush_all;
               end
            end
            WAIT: begin
               pc_n = target;
               if (bus.imem_rvalid) begin
                  drop_n = 1'b0;
                  st_n   = REQ;
               end else if (flush_all) begin
                  drop_n = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st      <= IDLE;
         pc      <= RESET_PC;
         tgt     <= 32'd0;
         opc     <= 32'd0;
         last_pc <= 32'd0;
         drop    <= 1'b0;
         pend    <= 1'b0;
         pdrop   <= 1'b0;
         cnt     <= 2'd0;
         ins0    <= 32'd0;
         ins1    <= 32'd0;
         pc0     <= 32'd0;
         pc1     <= 32'd0;
      end else begin
         st      <= st_n;
         pc      <= pc_n;
         tgt     <= tgt_n;
         opc     <= opc_n;
         last_pc <= bpc;
         drop    <= drop_n;
         pend    <= pend_n;
         pdrop   <= pdrop_n;
         cnt     <= n_cnt;
         ins0    <= n_ins0;
         ins1    <= n_ins1;
         pc0     <= n_pc0;
         pc1     <= n_pc1;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table plus redirect/reset runs.
// Memory contents in the hand-written runs are ~address.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = 26'd0;
   logic        mem_on = 1'b0;

   int total = 0;
   int bad = 0;

   logic [31:0] dlv[$];
   logic [31:0] dins[$];
   logic [31:0] exq[$];

   instr_fetch_if bus ();

   instr_fetch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_index   (jump_index)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        ir;
      logic        req;
      logic [31:0] addr;
      logic        iv;
      logic [31:0] ipc;
      logic [31:0] ins;
      logic        full;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic rst, input logic rdy, input logic rv,
      input logic [31:0] rd, input logic ir,
      input logic req, input logic [31:0] addr,
      input logic iv, input logic [31:0] ipc,
      input logic [31:0] ins, input logic full);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.rd = rd;
      v.ir = ir; v.req = req; v.addr = addr; v.iv = iv;
      v.ipc = ipc; v.ins = ins; v.full = full;
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   task automatic step();
      logic        acc;
      logic [31:0] a;
      acc = bus.imem_req && bus.imem_ready;
      a   = bus.imem_addr;
      if (bus.instr_valid && bus.instr_ready) begin
         dlv.push_back(bus.instr_pc);
         dins.push_back(bus.instr);
      end
      @(posedge clk);
      @(negedge clk);
      if (mem_on) begin
         bus.imem_rvalid = acc;
         bus.imem_rdata  = acc ? ~a : 32'd0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.imem_rvalid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      dlv.delete();
      dins.delete();
   endtask

   function automatic logic hit(input logic [31:0] a);
      return bus.imem_req && (bus.imem_addr == a);
   endfunction

   task automatic wait_pc(input logic [31:0] p, input string n);
      int k;
      k = 0;
      while (!(bus.instr_valid && bus.instr_pc == p) && k < 60) begin
         step();
         k++;
      end
      chk({n, " reach"}, {31'd0, bus.instr_valid && bus.instr_pc == p},
          32'd1);
   endtask

   task automatic redirect(input logic b, input logic j,
                           input logic [31:0] bt, input logic [25:0] ji,
                           input logic [31:0] et, input string n);
      logic seen;
      branch_taken  = b;
      jump          = j;
      branch_target = bt;
      jump_index    = ji;
      step();
      branch_taken = 1'b0;
      jump         = 1'b0;
      seen = hit(et);
      step();
      seen = seen | hit(et);
      chk({n, " tgt req"}, {31'd0, seen}, 32'd1);
   endtask

   task automatic check_list(input string n);
      logic [31:0] got;
      for (int i = 0; i < exq.size(); i++) begin
         got = (i < dlv.size()) ? dlv[i] : 32'hDEAD_BEEF;
         chk($sformatf("%s pc%0d", n, i), got, exq[i]);
         got = (i < dins.size()) ? dins[i] : 32'hDEAD_BEEF;
         chk($sformatf("%s ins%0d", n, i), got, ~exq[i]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      bus.imem_ready  = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'd0;
      bus.instr_ready = 1'b0;

      // rst rdy rv rdata ir | req addr iv ipc ins full
      tbl.push_back(mk(0,0,0,0,0,            0,0,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,1,            0,0,0,0,0,1));
      tbl.push_back(mk(1,1,0,0,1,            1,0,0,0,0,0));
      tbl.push_back(mk(1,1,1,32'h1111_0000,1, 0,4,0,0,0,0));
      tbl.push_back(mk(1,1,0,0,0,            1,4,1,0,32'h1111_0000,0));
      tbl.push_back(mk(1,0,1,32'h2222_0004,0, 0,8,1,0,32'h1111_0000,0));
      tbl.push_back(mk(1,1,0,0,0,            0,8,1,0,32'h1111_0000,0));
      tbl.push_back(mk(1,1,1,32'hDEAD_0000,0, 0,8,1,0,32'h1111_0000,0));
      for (int i = 0; i < 6; i++)
         tbl.push_back(mk(1,1,0,0,0,         0,8,1,0,32'h1111_0000,0));
      tbl.push_back(mk(1,1,0,0,1,            0,8,1,0,32'h1111_0000,0));
      tbl.push_back(mk(1,0,0,0,1,            1,8,1,4,32'h2222_0004,0));
      tbl.push_back(mk(1,1,0,0,1,            1,8,0,0,0,0));
      tbl.push_back(mk(1,1,1,32'h3333_0008,0, 0,12,0,0,0,0));
      tbl.push_back(mk(1,1,0,0,0,            1,12,1,8,32'h3333_0008,0));
      tbl.push_back(mk(1,1,1,32'h4444_000C,1, 0,16,1,8,32'h3333_0008,0));
      tbl.push_back(mk(1,0,0,0,1,            1,16,1,12,32'h4444_000C,0));
      tbl.push_back(mk(1,0,0,0,1,            1,16,0,0,0,0));

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         rst_n           = v.rst;
         bus.imem_ready  = v.rdy;
         bus.imem_rvalid = v.rv;
         bus.imem_rdata  = v.rd;
         bus.instr_ready = v.ir;
         chk($sformatf("r%0d req", i), {31'd0, bus.imem_req}, {31'd0, v.req});
         chk($sformatf("r%0d addr", i), bus.imem_addr, v.addr);
         chk($sformatf("r%0d ivalid", i), {31'd0, bus.instr_valid},
             {31'd0, v.iv});
         if (v.iv || v.full) begin
            chk($sformatf("r%0d ipc", i), bus.instr_pc, v.ipc);
            chk($sformatf("r%0d instr", i), bus.instr, v.ins);
         end
         @(posedge clk);
         @(negedge clk);
      end

      // Branch after decode accepts pc 8.
      mem_on = 1'b1;
      bus.imem_ready  = 1'b1;
      bus.instr_ready = 1'b1;
      do_reset();
      wait_pc(32'h8, "br");
      redirect(1'b1, 1'b0, 32'h0000_0103, 26'd0, 32'h100, "br");
      repeat (12) step();
      exq.delete();
`ifdef DELAY_SLOT_EN
      exq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100};
`else
      exq = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
`endif
      check_list("br");

      // Branch into 0x1000_0000, jump, then branch+jump together.
      do_reset();
      wait_pc(32'h0, "j0");
      redirect(1'b1, 1'b0, 32'h1000_0000, 26'd0, 32'h1000_0000, "j0");
      wait_pc(32'h1000_0008, "j1");
      redirect(1'b0, 1'b1, 32'h0, 26'h0000040, 32'h1000_0100, "j1");
      wait_pc(32'h1000_0100, "j2");
      redirect(1'b1, 1'b1, 32'h0000_2002, 26'h3FF_FFFF, 32'h2000, "j2");
      repeat (12) step();
      exq.delete();
`ifdef DELAY_SLOT_EN
      exq = '{32'h0, 32'h4, 32'h1000_0000, 32'h1000_0004,
              32'h1000_0008, 32'h1000_000C, 32'h1000_0100,
              32'h1000_0104, 32'h2000};
`else
      exq = '{32'h0, 32'h1000_0000, 32'h1000_0004, 32'h1000_0008,
              32'h1000_0100, 32'h2000, 32'h2004};
`endif
      check_list("jmp");

      // Reset while a response is outstanding; late rvalid is stale.
      mem_on = 1'b0;
      do_reset();
      step();
      chk("rst0 req", {31'd0, bus.imem_req}, 32'd1);
      step();
      chk("rst0 outst", {31'd0, bus.imem_req}, 32'd0);
      rst_n = 1'b0;
      bus.imem_ready = 1'b0;
      step();
      rst_n = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hBAD0_BAD0;
      chk("rst1 req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst1 addr", bus.imem_addr, 32'h0);
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'd0;
      chk("rst2 req", {31'd0, bus.imem_req}, 32'd1);
      chk("rst2 addr", bus.imem_addr, 32'h0);
      chk("rst2 ivalid", {31'd0, bus.instr_valid}, 32'd0);
      dlv.delete();
      dins.delete();
      mem_on = 1'b1;
      bus.imem_ready = 1'b1;
      for (int k = 0; k < 10 && dlv.size() == 0; k++)
         step();
      exq.delete();
      exq = '{32'h0};
      check_list("rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned read address, bits [1:0] always 0.
REQ-006 SHALL have port imem_ready  input  1  memory accepts request when imem_req && imem_ready.
REQ-007 SHALL have port imem_rvalid  input  1  read data valid, one pulse per accepted request, in order.
REQ-008 SHALL have port imem_rdata  input  32  instruction word.
REQ-009 SHALL have port instr_valid  output  1  instruction available to decode.
REQ-010 SHALL have port instr  output  32  instruction word; [31:26] opcode, [5:0] funct to control decoder.
REQ-011 SHALL have port instr_pc  output  32  address of instr.
REQ-012 SHALL have port instr_ready  input  1  decode accepts when instr_valid && instr_ready.
REQ-013 SHALL have port branch_taken  input  1  redirect to branch_target.
REQ-014 SHALL have port branch_target  output-side input  32  branch destination, bits [1:0] ignored.
REQ-015 SHALL have port jump  input  1  redirect to jump target.
REQ-016 SHALL have port jump_index  input  26  instruction index; target = {pc_of_branch+4 [31:28], jump_index, 2'b00}.

Function
REQ-017 SHALL hold a 2-entry in-order instruction buffer (instr, pc); instr/instr_pc/instr_valid driven from head register, no combinational path from imem_rdata.
REQ-018 SHALL keep at most one request outstanding; assert imem_req only when buffer count + outstanding < 2.
REQ-019 SHALL use FSM IDLE -> REQ (imem_req=1, hold imem_addr stable until accepted) -> WAIT (await imem_rvalid) -> REQ or IDLE (no space); IDLE -> REQ when space frees.
REQ-020 SHALL increment PC by 4 on each accepted request, wrapping 32'hFFFF_FFFC -> 0.
REQ-021 SHALL write imem_rdata into buffer on imem_rvalid; instr_valid rises the following cycle (min latency accept->instr_valid = 2 cycles).
REQ-022 SHALL pop head on instr_valid && instr_ready; simultaneous push and pop on a full or one-entry buffer SHALL neither lose nor duplicate entries.
REQ-023 SHALL treat a redirect (branch_taken || jump) as referring to the instruction accepted by decode in the same or any earlier cycle since the last redirect; branch_taken has priority when both asserted.
REQ-024 SHALL, on redirect, set PC to target (bits [1:0] zeroed) and issue the first request from target no later than 2 cycles after the redirect cycle.
REQ-025 SHALL, on redirect with a response outstanding, discard (not buffer) that response unless REQ-033 keeps it; a request already in REQ state SHALL complete its handshake at the old address before the target is issued.
REQ-026 SHALL ignore imem_rvalid when no request is outstanding.
REQ-027 SHALL not assert instr_valid in the cycle a redirect is applied for any flushed entry.

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, set PC=RESET_PC, FSM=IDLE, buffer empty, outstanding=0, pending redirect cleared.
REQ-029 SHALL drive imem_req=0, instr_valid=0, instr=0, instr_pc=0, imem_addr=RESET_PC during and immediately after reset.
REQ-030 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst_n returns to 1.
REQ-031 SHALL discard any response to a pre-reset request (per REQ-026).

Configuration
REQ-032 SHALL support macro DELAY_SLOT_EN selecting MIPS branch-delay-slot semantics.
REQ-033 SHALL, with DELAY_SLOT_EN defined, retain exactly one instruction (branch pc+4): kept at buffer head if present, else the outstanding response kept, else fetched before the target; entries after it flushed.
REQ-034 SHALL, without DELAY_SLOT_EN, flush all buffered entries and any outstanding response on redirect.

Verification
REQ-035 Reset release, imem_ready=1, rvalid 1 cycle after accept, instr_ready=1 -> addresses 0,4,8 issued; instr_valid first at cycle 3 with instr_pc=0.
REQ-036 instr_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req=0, no data lost; on release pcs 0,4,8 delivered in order.
REQ-037 branch_taken with branch_target=32'h0000_0103 after accepting pc 8, no DELAY_SLOT_EN -> next instr_pc=32'h100, pcs 12/16 never delivered.
REQ-038 Same with DELAY_SLOT_EN -> instr_pc 12 then 32'h100.
REQ-039 jump with jump_index=26'h0000040 at pc 32'h1000_0008 -> next fetch 32'h1000_0100; branch_taken and jump together -> branch_target wins.
REQ-040 rst_n low with response outstanding, rvalid arrives after release -> ignored; first delivered instr_pc=RESET_PC.
